// File: rtl/vx_tcu_int_acc_ctrl_if.sv
// Handshake and datapath bundle for the integer tensor-core accumulator controller.
// master = command/operand source and multiply datapath, slave = controller.
interface vx_tcu_int_acc_ctrl_if #(
    parameter int N              = 2,
    parameter int TCK            = 2 * N,
    parameter int KW             = 8,
    parameter int TCU_MAX_INPUTS = 8
);
    logic                           cmd_valid;
    logic                           cmd_ready;
    logic [2:0]                     cmd_fmt;
    logic [KW-1:0]                  cmd_ksteps;
    logic [TCU_MAX_INPUTS-1:0]      cmd_vld_mask;
    logic [7:0]                     cmd_sf_a;
    logic [7:0]                     cmd_sf_b;
    logic [TCK-1:0][31:0]           cmd_c;

    logic                           op_valid;
    logic                           op_ready;
    logic [N-1:0][31:0]             op_a_row;
    logic [N-1:0][31:0]             op_b_col;

    logic                           dp_valid;
    logic [2:0]                     dp_fmt;
    logic [TCU_MAX_INPUTS-1:0]      dp_vld_mask;
    logic [7:0]                     dp_sf_a;
    logic [7:0]                     dp_sf_b;
    logic [N-1:0][31:0]             dp_a_row;
    logic [N-1:0][31:0]             dp_b_col;
    logic [TCK-1:0][24:0]           dp_result;

    logic                           rsp_valid;
    logic                           rsp_ready;
    logic [TCK-1:0][31:0]           rsp_d;
    logic                           rsp_err;
    logic                           busy;

    modport master (
        output cmd_valid, cmd_fmt, cmd_ksteps, cmd_vld_mask,
        output cmd_sf_a, cmd_sf_b, cmd_c,
        output op_valid, op_a_row, op_b_col,
        output dp_result, rsp_ready,
        input  cmd_ready, op_ready,
        input  dp_valid, dp_fmt, dp_vld_mask, dp_sf_a, dp_sf_b,
        input  dp_a_row, dp_b_col,
        input  rsp_valid, rsp_d, rsp_err, busy
    );

    modport slave (
        input  cmd_valid, cmd_fmt, cmd_ksteps, cmd_vld_mask,
        input  cmd_sf_a, cmd_sf_b, cmd_c,
        input  op_valid, op_a_row, op_b_col,
        input  dp_result, rsp_ready,
        output cmd_ready, op_ready,
        output dp_valid, dp_fmt, dp_vld_mask, dp_sf_a, dp_sf_b,
        output dp_a_row, dp_b_col,
        output rsp_valid, rsp_d, rsp_err, busy
    );
endinterface

// File: rtl/vx_tcu_int_acc_ctrl.sv
// Integer tensor-core accumulate controller: command -> K operand beats -> response.
// Optional saturating accumulate when VX_TCU_INT_ACC_SAT_EN is defined.
module vx_tcu_int_acc_ctrl #(
    parameter int N              = 2,
    parameter int TCK            = 2 * N,
    parameter int KW             = 8,
    parameter int TCU_MAX_INPUTS = 8
) (
    input  logic                   clk,
    input  logic                   reset_n,
    vx_tcu_int_acc_ctrl_if.slave   bus
);
    localparam logic [2:0] FMT_I8   = 3'd0;
    localparam logic [2:0] FMT_U8   = 3'd1;
    localparam logic [2:0] FMT_I4   = 3'd2;
    localparam logic [2:0] FMT_U4   = 3'd3;
    localparam logic [2:0] FMT_MXI8 = 3'd4;

    typedef enum logic [1:0] {
        IDLE,
        STEP,
        DRAIN,
        DONE
    } state_e;

    state_e                    state_q, state_d;
    logic [KW-1:0]             cnt_q, cnt_d;
    logic [TCK-1:0][31:0]      acc_q, acc_d;
    logic                      dp_valid_q, dp_valid_d;
    logic [2:0]                dp_fmt_q, dp_fmt_d;
    logic [TCU_MAX_INPUTS-1:0] dp_mask_q, dp_mask_d;
    logic [7:0]                dp_sf_a_q, dp_sf_a_d;
    logic [7:0]                dp_sf_b_q, dp_sf_b_d;
    logic [N-1:0][31:0]        dp_a_q, dp_a_d;
    logic [N-1:0][31:0]        dp_b_q, dp_b_d;
    logic                      rsp_err_q, rsp_err_d;

    logic cmd_fire;
    logic op_fire;
    logic fmt_ok;
    logic fmt_signed;

    function automatic logic [31:0] acc_add(
        input logic [31:0] a,
        input logic [24:0] r,
        input logic        sgn
    );
        logic [31:0] e;
        logic [32:0] s;
        e = sgn ? {{7{r[24]}}, r} : {7'd0, r};
`ifdef VX_TCU_INT_ACC_SAT_EN
        if (sgn) begin
            s = {a[31], a} + {e[31], e};
            if (s[32] != s[31])
                acc_add = s[32] ? 32'h8000_0000 : 32'h7FFF_FFFF;
            else
                acc_add = s[31:0];
        end else begin
            s = {1'b0, a} + {1'b0, e};
            acc_add = s[32] ? 32'hFFFF_FFFF : s[31:0];
        end
`else
        s = {1'b0, a} + {1'b0, e};
        acc_add = s[31:0];
`endif
    endfunction

    assign fmt_ok     = (bus.cmd_fmt <= FMT_MXI8);
    assign fmt_signed = (dp_fmt_q == FMT_I8) || (dp_fmt_q == FMT_I4)
                     || (dp_fmt_q == FMT_MXI8);

    assign bus.cmd_ready = (state_q == IDLE);
    assign bus.op_ready  = (state_q == STEP) && (cnt_q != '0);
    assign cmd_fire      = bus.cmd_valid && bus.cmd_ready;
    assign op_fire       = bus.op_valid && bus.op_ready;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        acc_d      = acc_q;
        dp_valid_d = 1'b0;
        dp_fmt_d   = dp_fmt_q;
        dp_mask_d  = dp_mask_q;
        dp_sf_a_d  = dp_sf_a_q;
        dp_sf_b_d  = dp_sf_b_q;
        dp_a_d     = dp_a_q;
        dp_b_d     = dp_b_q;
        rsp_err_d  = rsp_err_q;

        // The beat issued last cycle folds in while the next beat is accepted.
        if (dp_valid_q) begin
            for (int i = 0; i < TCK; i++)
                acc_d[i] = acc_add(acc_q[i], bus.dp_result[i], fmt_signed);
        end

        unique case (state_q)
            IDLE: begin
                if (cmd_fire) begin
                    dp_fmt_d  = bus.cmd_fmt;
                    dp_mask_d = bus.cmd_vld_mask;
                    dp_sf_a_d = bus.cmd_sf_a;
                    dp_sf_b_d = bus.cmd_sf_b;
                    acc_d     = bus.cmd_c;
                    cnt_d     = bus.cmd_ksteps;
                    rsp_err_d = !fmt_ok;
                    if (fmt_ok && (bus.cmd_ksteps != '0))
                        state_d = STEP;
                    else
                        state_d = DONE;
                end
            end
            STEP: begin
                if (op_fire) begin
                    dp_a_d     = bus.op_a_row;
                    dp_b_d     = bus.op_b_col;
                    dp_valid_d = 1'b1;
                    cnt_d      = cnt_q - KW'(1);
                    if (cnt_q == KW'(1))
                        state_d = DRAIN;
                end
            end
            DRAIN: state_d = DONE;
            DONE: begin
                if (bus.rsp_ready) begin
                    state_d   = IDLE;
                    rsp_err_d = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            acc_q      <= '0;
            dp_valid_q <= 1'b0;
            dp_fmt_q   <= '0;
            dp_mask_q  <= '0;
            dp_sf_a_q  <= '0;
            dp_sf_b_q  <= '0;
            dp_a_q     <= '0;
            dp_b_q     <= '0;
            rsp_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            acc_q      <= acc_d;
            dp_valid_q <= dp_valid_d;
            dp_fmt_q   <= dp_fmt_d;
            dp_mask_q  <= dp_mask_d;
            dp_sf_a_q  <= dp_sf_a_d;
            dp_sf_b_q  <= dp_sf_b_d;
            dp_a_q     <= dp_a_d;
            dp_b_q     <= dp_b_d;
            rsp_err_q  <= rsp_err_d;
        end
    end

    assign bus.dp_valid    = dp_valid_q;
    assign bus.dp_fmt      = dp_fmt_q;
    assign bus.dp_vld_mask = dp_mask_q;
    assign bus.dp_sf_a     = dp_sf_a_q;
    assign bus.dp_sf_b     = dp_sf_b_q;
    assign bus.dp_a_row    = dp_a_q;
    assign bus.dp_b_col    = dp_b_q;
    assign bus.rsp_valid   = (state_q == DONE);
    assign bus.rsp_d       = acc_q;
    assign bus.rsp_err     = rsp_err_q;
    assign bus.busy        = (state_q != IDLE);

endmodule

// File: tb/tb_vx_tcu_int_acc_ctrl.sv
// Directed bench for vx_tcu_int_acc_ctrl; the multiply datapath is mocked
// as lane0=a[0], lane1=b[0], lane2=a[1], lane3=b[1] (low 25 bits).
module tb_vx_tcu_int_acc_ctrl;
    localparam int N   = 2;
    localparam int TCK = 4;
    localparam int KW  = 8;
    localparam int MI  = 8;

    localparam logic [2:0] I8   = 3'd0;
    localparam logic [2:0] U8   = 3'd1;
    localparam logic [2:0] I4   = 3'd2;
    localparam logic [2:0] U4   = 3'd3;
    localparam logic [2:0] MXI8 = 3'd4;
    localparam logic [2:0] BADF = 3'd7;

    logic clk;
    logic reset_n;
    int   total;
    int   bad;
    int   dp_pulses;

    vx_tcu_int_acc_ctrl_if #(.N(N), .TCK(TCK), .KW(KW), .TCU_MAX_INPUTS(MI)) bus ();

    vx_tcu_int_acc_ctrl #(.N(N), .TCK(TCK), .KW(KW), .TCU_MAX_INPUTS(MI)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        bus.dp_result[0] = bus.dp_a_row[0][24:0];
        bus.dp_result[1] = bus.dp_b_col[0][24:0];
        bus.dp_result[2] = bus.dp_a_row[1][24:0];
        bus.dp_result[3] = bus.dp_b_col[1][24:0];
    end

    always @(negedge clk) if (bus.dp_valid === 1'b1) dp_pulses = dp_pulses + 1;

    task automatic run_txn(
        input  logic [2:0]  fmt,
        input  logic [7:0]  ks,
        input  int          nb,
        input  logic [31:0] c0,
        input  logic [31:0] c1,
        input  logic [31:0] a0,
        input  logic [31:0] b0,
        output logic [31:0] d0,
        output logic [31:0] d1,
        output logic        e,
        output int          lat
    );
        @(negedge clk);
        bus.cmd_valid    = 1'b1;
        bus.cmd_fmt      = fmt;
        bus.cmd_ksteps   = ks;
        bus.cmd_vld_mask = 8'hFF;
        bus.cmd_sf_a     = 8'h11;
        bus.cmd_sf_b     = 8'h22;
        bus.cmd_c        = {32'd0, 32'd0, c1, c0};
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        for (int k = 0; k < nb; k++) begin
            bus.op_valid = 1'b1;
            bus.op_a_row = {32'd0, a0};
            bus.op_b_col = {32'd0, b0};
            @(negedge clk);
        end
        bus.op_valid = 1'b0;
        lat = 0;
        while (bus.rsp_valid !== 1'b1 && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        if (lat >= 20) begin
            total++;
            bad++;
            $display("FAIL rsp_timeout got no rsp_valid req rsp_valid within 20 cycles");
        end
        d0 = bus.rsp_d[0];
        d1 = bus.rsp_d[1];
        e  = bus.rsp_err;
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        bus.rsp_ready = 1'b0;
    endtask

    task automatic test_reset;
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        total++;
        if ({bus.op_ready, bus.dp_valid, bus.rsp_valid, bus.rsp_err, bus.busy} !== 5'b0) begin
            bad++;
            $display("FAIL reset_ctrl got %b req 00000",
                {bus.op_ready, bus.dp_valid, bus.rsp_valid, bus.rsp_err, bus.busy});
        end
        total++;
        if (bus.rsp_d !== '0 || bus.dp_a_row !== '0 || bus.dp_fmt !== 3'd0) begin
            bad++;
            $display("FAIL reset_data got rsp_d=%h dp_a=%h req 0", bus.rsp_d, bus.dp_a_row);
        end
        reset_n = 1'b1;
        @(negedge clk);
        total++;
        if (bus.cmd_ready !== 1'b1) begin
            bad++;
            $display("FAIL reset_cmd_ready got %b req 1", bus.cmd_ready);
        end
    endtask

    task automatic test_i8_sum;
        logic [31:0] d0, d1;
        logic        e;
        int          lat;
        int          p0;
        p0 = dp_pulses;
        run_txn(I8, 8'd3, 3, 32'd0, 32'd0, 32'd100, 32'h01FF_FFFF, d0, d1, e, lat);
        total++;
        if (d0 !== 32'd300) begin
            bad++;
            $display("FAIL i8_sum_lane0 got %0d req 300", d0);
        end
        total++;
        if (d1 !== 32'hFFFF_FFFD) begin
            bad++;
            $display("FAIL i8_sum_lane1 got %h req fffffffd", d1);
        end
        total++;
        if (lat !== 1) begin
            bad++;
            $display("FAIL i8_latency got %0d req 1 (t+2)", lat);
        end
        total++;
        if (dp_pulses - p0 !== 3) begin
            bad++;
            $display("FAIL i8_dp_pulses got %0d req 3", dp_pulses - p0);
        end
        total++;
        if (bus.busy !== 1'b0 || bus.cmd_ready !== 1'b1) begin
            bad++;
            $display("FAIL i8_return_idle got busy=%b cmd_ready=%b req 0/1",
                bus.busy, bus.cmd_ready);
        end
    endtask

    task automatic test_extend;
        logic [31:0] d0, d1;
        logic        e;
        int          lat;
        run_txn(U4, 8'd1, 1, 32'd0, 32'd0, 32'h01FF_FFFF, 32'd0, d0, d1, e, lat);
        total++;
        if (d0 !== 32'h01FF_FFFF) begin
            bad++;
            $display("FAIL u4_zext got %h req 01ffffff", d0);
        end
        run_txn(I4, 8'd1, 1, 32'd0, 32'd0, 32'h01FF_FFFF, 32'd0, d0, d1, e, lat);
        total++;
        if (d0 !== 32'hFFFF_FFFF) begin
            bad++;
            $display("FAIL i4_sext got %h req ffffffff", d0);
        end
        run_txn(MXI8, 8'd2, 2, 32'd0, 32'd0, 32'h01FF_FFFF, 32'd0, d0, d1, e, lat);
        total++;
        if (d0 !== 32'hFFFF_FFFE) begin
            bad++;
            $display("FAIL mxi8_sext got %h req fffffffe", d0);
        end
        run_txn(U8, 8'd2, 2, 32'd0, 32'd0, 32'h01FF_FFFF, 32'd0, d0, d1, e, lat);
        total++;
        if (d0 !== 32'h03FF_FFFE) begin
            bad++;
            $display("FAIL u8_zext got %h req 03fffffe", d0);
        end
    endtask

    task automatic test_zero_and_bad;
        logic [31:0] d0, d1;
        logic        e;
        int          lat;
        int          p0;
        p0 = dp_pulses;
        run_txn(I8, 8'd0, 0, 32'd5, 32'd7, 32'd0, 32'd0, d0, d1, e, lat);
        total++;
        if (d1 !== 32'd7 || d0 !== 32'd5) begin
            bad++;
            $display("FAIL zero_ks_data got %0d/%0d req 5/7", d0, d1);
        end
        total++;
        if (lat !== 0) begin
            bad++;
            $display("FAIL zero_ks_latency got %0d req 0 (t+1)", lat);
        end
        total++;
        if (dp_pulses !== p0 || e !== 1'b0) begin
            bad++;
            $display("FAIL zero_ks_dp got pulses=%0d err=%b req 0/0", dp_pulses - p0, e);
        end
        run_txn(BADF, 8'd2, 0, 32'h1234, 32'h5678, 32'd0, 32'd0, d0, d1, e, lat);
        total++;
        if (e !== 1'b1) begin
            bad++;
            $display("FAIL bad_fmt_err got %b req 1", e);
        end
        total++;
        if (d0 !== 32'h1234 || d1 !== 32'h5678 || dp_pulses !== p0) begin
            bad++;
            $display("FAIL bad_fmt_data got %h/%h pulses=%0d req 1234/5678/0",
                d0, d1, dp_pulses - p0);
        end
        total++;
        if (bus.rsp_err !== 1'b0) begin
            bad++;
            $display("FAIL bad_fmt_err_clear got %b req 0", bus.rsp_err);
        end
    endtask

    task automatic test_wrap;
        logic [31:0] d0, d1;
        logic [31:0] exp0;
        logic        e;
        int          lat;
`ifdef VX_TCU_INT_ACC_SAT_EN
        exp0 = 32'h7FFF_FFFF;
`else
        exp0 = 32'h8000_0010;
`endif
        run_txn(I8, 8'd1, 1, 32'h7FFF_FFF0, 32'd0, 32'd32, 32'd0, d0, d1, e, lat);
        total++;
        if (d0 !== exp0) begin
            bad++;
            $display("FAIL i8_overflow got %h req %h", d0, exp0);
        end
    endtask

    task automatic test_stall;
        logic [31:0] snap;
        logic [4:0]  pat;
        int          beat;
        int          n;
        pat  = 5'b10110;
        beat = 1;
        @(negedge clk);
        bus.cmd_valid  = 1'b1;
        bus.cmd_fmt    = I8;
        bus.cmd_ksteps = 8'd4;
        bus.cmd_sf_a   = 8'h5A;
        bus.cmd_c      = {32'd0, 32'd0, 32'd0, 32'd10};
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        total++;
        if (bus.dp_sf_a !== 8'h5A || bus.cmd_ready !== 1'b0) begin
            bad++;
            $display("FAIL stall_latch got sf_a=%h cmd_ready=%b req 5a/0",
                bus.dp_sf_a, bus.cmd_ready);
        end
        n = 0;
        while (beat <= 4 && n < 30) begin
            bus.op_valid = pat[n % 5];
            bus.op_a_row = {32'd0, pat[n % 5] ? 32'(beat) : 32'd999};
            bus.op_b_col = {32'd0, 32'h01FF_FFFF};
            if (pat[n % 5]) beat++;
            @(negedge clk);
            n++;
        end
        bus.op_valid = 1'b0;
        n = 0;
        while (bus.rsp_valid !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        total++;
        if (bus.rsp_d[0] !== 32'd20 || bus.rsp_d[1] !== 32'hFFFF_FFFC) begin
            bad++;
            $display("FAIL stall_sum got %h/%h req 00000014/fffffffc",
                bus.rsp_d[0], bus.rsp_d[1]);
        end
        snap = bus.rsp_d[0];
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            total++;
            if (bus.rsp_valid !== 1'b1 || bus.rsp_d[0] !== snap) begin
                bad++;
                $display("FAIL stall_hold got valid=%b d0=%h req 1/%h",
                    bus.rsp_valid, bus.rsp_d[0], snap);
            end
        end
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        bus.rsp_ready = 1'b0;
    endtask

    task automatic test_reset_mid;
        @(negedge clk);
        bus.cmd_valid  = 1'b1;
        bus.cmd_fmt    = I8;
        bus.cmd_ksteps = 8'd4;
        bus.cmd_c      = {32'd0, 32'd0, 32'd0, 32'd3};
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        bus.op_valid  = 1'b1;
        bus.op_a_row  = {32'd0, 32'd9};
        repeat (2) @(negedge clk);
        bus.op_valid = 1'b0;
        reset_n = 1'b0;
        @(negedge clk);
        total++;
        if ({bus.op_ready, bus.dp_valid, bus.rsp_valid, bus.busy, bus.cmd_ready} !== 5'b00001) begin
            bad++;
            $display("FAIL mid_reset_ctrl got %b req 00001",
                {bus.op_ready, bus.dp_valid, bus.rsp_valid, bus.busy, bus.cmd_ready});
        end
        total++;
        if (bus.rsp_d !== '0 || bus.dp_a_row !== '0) begin
            bad++;
            $display("FAIL mid_reset_data got %h req 0", bus.rsp_d);
        end
        reset_n = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            total++;
            if (bus.rsp_valid !== 1'b0 || bus.busy !== 1'b0) begin
                bad++;
                $display("FAIL mid_reset_no_rsp got valid=%b busy=%b req 0/0",
                    bus.rsp_valid, bus.busy);
            end
        end
    endtask

    initial begin
        total = 0;
        bad = 0;
        dp_pulses = 0;
        reset_n = 1'b0;
        bus.cmd_valid = 1'b0;
        bus.cmd_fmt = '0;
        bus.cmd_ksteps = '0;
        bus.cmd_vld_mask = '0;
        bus.cmd_sf_a = '0;
        bus.cmd_sf_b = '0;
        bus.cmd_c = '0;
        bus.op_valid = 1'b0;
        bus.op_a_row = '0;
        bus.op_b_col = '0;
        bus.rsp_ready = 1'b0;
        test_reset();
        test_i8_sum();
        test_extend();
        test_zero_and_bad();
        test_wrap();
        test_stall();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
